// File: rtl/fact_bcd_converter_pkg.sv
// Shared types and constants for the factorial BCD converter.
// Optional build macro: FACT_BCD_BLANK_EN (leading-zero blanking and error digit codes).
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit bcd_digits_ok(input int width, input int digits);
        longint unsigned pow10;
        longint unsigned maxv;
        pow10 = 64'd1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        maxv = (64'd1 << width) - 64'd1;
        return (pow10 > maxv);
    endfunction

endpackage

// File: rtl/fact_bcd_converter_if.sv
// Handshake bundle between the factorial engine, the converter and the readout.
interface fact_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic [WIDTH-1:0]      in_value;
    logic                  in_error;
    logic                  in_ready;
    logic                  drop;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_error;

    // Engine and readout side.
    modport master (
        output in_valid, in_value, in_error, out_ready,
        input  in_ready, drop, out_valid, out_bcd, out_error
    );

    // Converter side.
    modport slave (
        input  in_valid, in_value, in_error, out_ready,
        output in_ready, drop, out_valid, out_bcd, out_error
    );
endinterface

// File: rtl/fact_bcd_converter_bcd_digit_adj.sv
// One BCD digit correction step of double-dabble: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    // Add-3 correction, wraps within the nibble.
    always_comb begin
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end else begin
            d_o = d_i;
        end
    end
endmodule

// File: rtl/fact_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// valid/ready handshake toward the readout and overrun detection.
// Optional build macro: FACT_BCD_BLANK_EN (blank leading zeros as 4'hF, error digits 4'hE).
module fact_bcd_converter
    import fact_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    fact_bcd_converter_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (!bcd_digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("fact_bcd_converter: DIGITS too small for WIDTH");
    end

    state_e          state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BW-1:0]   acc_q;
    logic [CW-1:0]   count_q;
    logic [BW-1:0]   out_bcd_q;
    logic            out_error_q;
    logic            out_valid_q;
    logic            drop_q;

    logic [BW-1:0]    adj_s;
    logic [BW-1:0]    acc_shift_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [BW-1:0]    xfer_bcd_s;
    logic [BW-1:0]    err_bcd_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (adj_s[4*g +: 4])
        );
    end

`ifdef FACT_BCD_BLANK_EN
    // Replace leading zero digits by the blank code; digit 0 is never blanked.
    function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          lead;
        r    = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (v[4*i +: 4] == 4'h0)) begin
                r[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    // Adjusted accumulator shifted left together with the binary register; result formatting.
    always_comb begin
        {acc_shift_s, shift_next_s} = {adj_s, shift_q} << 1;
`ifdef FACT_BCD_BLANK_EN
        xfer_bcd_s = blank_lead(acc_shift_s);
        err_bcd_s  = {DIGITS{BCD_ERR}};
`else
        xfer_bcd_s = acc_shift_s;
        err_bcd_s  = {BW{1'b0}};
`endif
    end

    // Control FSM with conversion datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= {WIDTH{1'b0}};
            acc_q       <= {BW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_bcd_q   <= {BW{1'b0}};
            out_error_q <= 1'b0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= bus.in_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_error) begin
                            out_bcd_q   <= err_bcd_s;
                            out_error_q <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            shift_q <= bus.in_value;
                            acc_q   <= {BW{1'b0}};
                            count_q <= CW'(WIDTH);
                            state_q <= SHIFT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_shift_s;
                    shift_q <= shift_next_s;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        out_bcd_q   <= xfer_bcd_s;
                        out_error_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.drop      = drop_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_error = out_error_q;

endmodule

// File: tb/tb_fact_bcd_converter.sv
// Directed plus randomized bench for fact_bcd_converter with a decimal reference model.
module tb_fact_bcd_converter;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   edges;

    fact_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    fact_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected digits from decimal arithmetic on the value.
    function automatic logic [19:0] ref_bcd(input int v, input bit err);
        logic [19:0] r;
        int p;
        int nd;
        r = 20'h0;
        if (err) begin
`ifdef FACT_BCD_BLANK_EN
            return 20'hEEEEE;
`else
            return 20'h00000;
`endif
        end
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
`ifdef FACT_BCD_BLANK_EN
        nd = 1;
        p  = 10;
        while (v >= p) begin
            nd++;
            p = p * 10;
        end
        for (int i = nd; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
`else
        nd = 0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic send(input int v, input bit err);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_value = 16'(v);
        bus.in_error = err;
        tick();
        bus.in_valid = 1'b0;
        bus.in_error = 1'b0;
        edges = 0;
    endtask

    task automatic wait_valid(input int exp_lat, input int v, input bit err, input string tag);
        while (!bus.out_valid && edges < 40) tick();
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_bcd"}, 32'(bus.out_bcd), 32'(ref_bcd(v, err)));
        check({tag, "_err"}, 32'(bus.out_error), 32'(err));
        check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int v;
        checks   = 0;
        failures = 0;
        edges    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value  = 16'h0;
        bus.in_error  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
        check("rst_drop", 32'(bus.drop), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 120 with an overrun during SHIFT and a stall with overrun in HOLD
        send(120, 1'b0);
        repeat (5) tick();
        bus.in_valid = 1'b1;
        bus.in_value = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        check("shift_drop_high", 32'(bus.drop), 32'd1);
        check("shift_no_accept", 32'(bus.in_ready), 32'd0);
        tick();
        check("shift_drop_low", 32'(bus.drop), 32'd0);
        wait_valid(WIDTH, 120, 1'b0, "v120");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.in_value = 16'h0042;
            end
            tick();
            bus.in_valid = 1'b0;
            check("hold_drop", 32'(bus.drop), 32'(i == 3));
            check("hold_bcd_stable", 32'(bus.out_bcd), 32'(ref_bcd(120, 1'b0)));
            check("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        release_result("v120");

        // Back-to-back 40320 then 0 with out_ready held high
        bus.out_ready = 1'b1;
        send(40320, 1'b0);
        wait_valid(WIDTH, 40320, 1'b0, "v40320");
        send(0, 1'b0);
        wait_valid(WIDTH, 0, 1'b0, "v0");
        tick();
        bus.out_ready = 1'b0;
        check("b2b_idle", 32'(bus.in_ready), 32'd1);

        // Upstream error
        send(16'h9980, 1'b1);
        wait_valid(0, 16'h9980, 1'b1, "err");
        release_result("err");

        // Randomized values
        for (int k = 0; k < 10; k++) begin
            v = int'($urandom_range(65535, 0));
            send(v, 1'b0);
            wait_valid(WIDTH, v, 1'b0, "rand");
            repeat ($urandom_range(2, 0)) tick();
            release_result("rand");
        end

        // Previous result left in out_bcd, then reset in the middle of SHIFT
        send(9999, 1'b0);
        wait_valid(WIDTH, 9999, 1'b0, "pre_rst");
        release_result("pre_rst");
        send(12345, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_bcd", 32'(bus.out_bcd), 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("midrst_no_result", 32'(bus.out_valid), 32'd0);
        send(65535, 1'b0);
        wait_valid(WIDTH, 65535, 1'b0, "v65535");
        release_result("v65535");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fact_bcd_converter.md
Name: fact_bcd_converter

Overview:
- Downstream stage of the factorial engine. Consumes its 16-bit result plus its done/error pulse.
- Converts the binary result to packed BCD with a sequential shift-add-3 (double-dabble), one bit per clock.
- Presents the digits to the display/readout logic over a valid/ready handshake.
- Wiring: in_valid is driven by the engine's done pulse, in_error by its error flag, in_value by its result bus.

Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; elaboration-time assertion otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input value present; single-cycle pulse tolerated.
- in_value  in  WIDTH  binary value to convert.
- in_error  in  1  upstream overflow; value is meaningless.
- in_ready  out  1  converter idle, will accept this cycle.
- drop  out  1  one-cycle pulse: in_valid seen while in_ready=0.
- out_valid  out  1  out_bcd/out_error valid.
- out_ready  in  1  consumer accepts result.
- out_bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0].
- out_error  out  1  result is an upstream error.

Behaviour:
- Reset (async, any state including mid-conversion):
  - state=IDLE, out_bcd=0, out_valid=0, out_error=0, drop=0, shift/count registers cleared.
  - in_ready=1 from the first cycle after reset.
- State machine: IDLE, SHIFT, HOLD.
- in_ready is combinational: in_ready = (state==IDLE). out_valid is registered: high exactly in HOLD.
- IDLE:
  - On in_valid with in_error=0: capture in_value into the shift register, clear the BCD accumulator, load count=WIDTH, go to SHIFT.
  - On in_valid with in_error=1: load out_bcd=0 and out_error=1, go to HOLD. out_valid rises on the next edge.
- SHIFT, once per cycle:
  - Each accumulator digit >=5 gets +3, mod 16 within its nibble.
  - Then shift {accumulator, shift register} left by 1. The MSB of the shift register enters BCD bit 0.
  - Decrement count. On the edge where count reaches 0, transfer the accumulator to out_bcd, set out_error=0, go to HOLD.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge (16 by default). Throughput is one result per WIDTH+2 cycles minimum.
- HOLD:
  - out_bcd and out_error stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE on that edge. No same-cycle bypass, so a new input is accepted no earlier than the following cycle.
- Overrun:
  - in_valid while in SHIFT or HOLD is ignored; drop pulses high the next cycle.
  - The in-flight conversion is unaffected.
- Arithmetic: widths are fixed. The accumulator is 4*DIGITS bits and never overflows under the DIGITS constraint.
- Boundary values: value 0 gives all-zero digits; value 2^WIDTH-1 gives correct digits (65535 → 20'h65535).

Optional Feature:
- Macro FACT_BCD_BLANK_EN.
- Defined:
  - At transfer to out_bcd, leading zero digits are replaced by 4'hF (blank code). Digit 0 is always shown.
  - Error results present all digits as 4'hE.
- Undefined: plain BCD, leading zeros kept, error digits 0.
- Handshake and latency are identical in both builds.

Decomposition:
- Package fact_pkg:
  - state enum typedef (IDLE, SHIFT, HOLD);
  - localparams BCD_BLANK=4'hF and BCD_ERR=4'hE;
  - helper function for the DIGITS sizing check.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, adds 3 when >=5. Instantiated DIGITS times via generate.

Test Plan:
- Value 120, in_error=0 → out_valid 16 cycles after accept; out_bcd=20'h00120 (blank build: 20'hFFF20 is wrong, expect 20'hFF120); out_error=0.
- Value 40320, then value 0 back-to-back with out_ready=1 → 20'h40320, then 20'h00000 (blank build: 20'hFFFF0).
- in_error=1 with value 16'h9980 → out_valid next cycle, out_error=1, out_bcd=0 (blank build: 20'hEEEEE).
- out_ready low 10 cycles in HOLD; pulse in_valid during HOLD and during SHIFT → out_bcd stable, drop=1 for one cycle each, no new acceptance.
- Assert rst at SHIFT cycle 7 → out_valid=0, in_ready=1, out_bcd=0 immediately. Then convert 65535 → 20'h65535.
